// File: rtl/pld_config_ctrl_pkg.sv
// Shared types and size helpers for the pld fuse configuration controller.
package pld_config_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCheck,
      StCommit,
      StDone,
      StError
   } state_e;

   function automatic int unsigned and_bits(input int unsigned n);
      return (32'd1 << (n + 2)) * n * n;
   endfunction

   function automatic int unsigned or_bits(input int unsigned n, input int unsigned m);
      return m * (32'd1 << (2 * n));
   endfunction

   // Enough W-bit words to cover every AND and OR fuse.
   function automatic int unsigned num_words(input int unsigned n, input int unsigned m,
                                             input int unsigned w);
      return (and_bits(n) + or_bits(n, m) + w - 1) / w;
   endfunction

   localparam int unsigned DefAndBits  = and_bits(2);
   localparam int unsigned DefOrBits   = or_bits(2, 2);
   localparam int unsigned DefNumWords = num_words(2, 2, 8);

endpackage

// File: rtl/pld_config_ctrl.sv
// Streams fuse words into a shadow register, verifies an XOR checksum and commits the
// shadow atomically to the active AND/OR fuse outputs.
module pld_config_ctrl
   import pld_config_ctrl_pkg::*;
#(
   parameter int unsigned NUM_PORTS_IN  = 2,
   parameter int unsigned NUM_PORTS_OUT = 2,
   parameter int unsigned CFG_WIDTH     = 8,
   localparam int unsigned AND_BITS     = and_bits(NUM_PORTS_IN),
   localparam int unsigned OR_BITS      = or_bits(NUM_PORTS_IN, NUM_PORTS_OUT)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 prog_start_i,
   input  logic                 prog_abort_i,
   input  logic [CFG_WIDTH-1:0] cfg_data_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   output logic [AND_BITS-1:0]  and_matrix_fuses_conf_o,
   output logic [OR_BITS-1:0]   or_matrix_fuses_conf_o,
   output logic                 programmed_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o
);

   localparam int unsigned NUM_WORDS = num_words(NUM_PORTS_IN, NUM_PORTS_OUT, CFG_WIDTH);
   localparam int unsigned ACT_BITS  = AND_BITS + OR_BITS;
   localparam int unsigned SH_BITS   = NUM_WORDS * CFG_WIDTH;
   localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   state_e               r_state,   w_state_d;
   logic [CNT_W-1:0]     r_cnt,     w_cnt_d;
   logic [CFG_WIDTH-1:0] r_acc,     w_acc_d;
   logic [CFG_WIDTH-1:0] r_csum,    w_csum_d;
   logic [SH_BITS-1:0]   r_shadow,  w_shadow_d;
   logic [ACT_BITS-1:0]  r_active,  w_active_d;
   logic                 r_programmed, w_programmed_d;
   logic                 r_done,    w_done_d;
   logic                 r_error,   w_error_d;
   logic                 w_ready;
   logic                 w_busy;

   always_comb begin
      w_state_d      = r_state;
      w_cnt_d        = r_cnt;
      w_acc_d        = r_acc;
      w_csum_d       = r_csum;
      w_shadow_d     = r_shadow;
      w_active_d     = r_active;
      w_programmed_d = r_programmed;
      w_done_d       = 1'b0;
      w_error_d      = r_error;
      w_ready        = 1'b0;
      w_busy         = 1'b0;

      unique case (r_state)
         StIdle, StDone, StError: begin
            if (prog_start_i) begin
               w_state_d  = StLoad;
               w_cnt_d    = '0;
               w_acc_d    = '0;
               w_shadow_d = '0;
               w_error_d  = 1'b0;
            end
         end
         StLoad: begin
            w_ready = 1'b1;
            w_busy  = 1'b1;
            // Abort beats a handshake in the same cycle; the active config is left alone.
            if (prog_abort_i) begin
               w_state_d  = StIdle;
               w_cnt_d    = '0;
               w_acc_d    = '0;
               w_shadow_d = '0;
            end else if (cfg_valid_i) begin
               for (int unsigned k = 0; k < NUM_WORDS; k++) begin
                  if (r_cnt == CNT_W'(k)) begin
                     w_shadow_d[k*CFG_WIDTH +: CFG_WIDTH] = cfg_data_i;
                  end
               end
               w_acc_d = r_acc ^ cfg_data_i;
               if (r_cnt == CNT_W'(NUM_WORDS - 1)) begin
                  w_state_d = StCheck;
                  w_cnt_d   = '0;
               end else begin
                  w_cnt_d = r_cnt + 1'b1;
               end
            end
         end
         StCheck: begin
            w_ready = 1'b1;
            w_busy  = 1'b1;
            if (prog_abort_i) begin
               w_state_d  = StIdle;
               w_cnt_d    = '0;
               w_acc_d    = '0;
               w_shadow_d = '0;
            end else if (cfg_valid_i) begin
               w_csum_d  = cfg_data_i;
               w_state_d = StCommit;
            end
         end
         StCommit: begin
            w_busy = 1'b1;
            if (r_csum == r_acc) begin
               // Padding bits past the last fuse are checksummed but never committed.
               w_active_d     = r_shadow[ACT_BITS-1:0];
               w_programmed_d = 1'b1;
               w_done_d       = 1'b1;
               w_state_d      = StDone;
            end else begin
               w_error_d = 1'b1;
               w_state_d = StError;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= StIdle;
         r_cnt        <= '0;
         r_acc        <= '0;
         r_csum       <= '0;
         r_shadow     <= '0;
         r_active     <= '0;
         r_programmed <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_cnt        <= w_cnt_d;
         r_acc        <= w_acc_d;
         r_csum       <= w_csum_d;
         r_shadow     <= w_shadow_d;
         r_active     <= w_active_d;
         r_programmed <= w_programmed_d;
         r_done       <= w_done_d;
         r_error      <= w_error_d;
      end
   end

   assign cfg_ready_o             = w_ready;
   assign busy_o                  = w_busy;
   assign done_o                  = r_done;
   assign error_o                 = r_error;
   assign programmed_o            = r_programmed;
   assign and_matrix_fuses_conf_o = r_active[AND_BITS-1:0];
   assign or_matrix_fuses_conf_o  = r_active[AND_BITS +: OR_BITS];

endmodule

// File: tb/tb_pld_config_ctrl.sv
// Directed self-checking bench for pld_config_ctrl at default parameters.
module tb_pld_config_ctrl;

   localparam logic [63:0] AndPat = 64'h0807_0605_0403_0201;
   localparam logic [31:0] OrPat  = 32'h0C0B_0A09;

   logic        clk;
   logic        rst_n;
   logic        prog_start;
   logic        prog_abort;
   logic [7:0]  cfg_data;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [63:0] and_conf;
   logic [31:0] or_conf;
   logic        programmed;
   logic        busy;
   logic        done;
   logic        error;

   int n_total = 0;
   int n_bad   = 0;

   pld_config_ctrl dut (
      .clk_i                   (clk),
      .rst_ni                  (rst_n),
      .prog_start_i            (prog_start),
      .prog_abort_i            (prog_abort),
      .cfg_data_i              (cfg_data),
      .cfg_valid_i             (cfg_valid),
      .cfg_ready_o             (cfg_ready),
      .and_matrix_fuses_conf_o (and_conf),
      .or_matrix_fuses_conf_o  (or_conf),
      .programmed_o            (programmed),
      .busy_o                  (busy),
      .done_o                  (done),
      .error_o                 (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; leaves the DUT in LOAD at the next negedge.
   task automatic start_load();
      prog_start = 1'b1;
      @(negedge clk);
      prog_start = 1'b0;
   endtask

   // Presents one word (optionally after a short random gap) and waits for its handshake edge.
   task automatic push(input logic [7:0] d, input bit gaps);
      int g = 0;
      while (gaps && g < 4 && $urandom_range(0, 1) == 1) begin
         cfg_valid = 1'b0;
         @(negedge clk);
         g++;
      end
      cfg_valid = 1'b1;
      cfg_data  = d;
      check("ready_during_load", cfg_ready, 1'b1);
      @(negedge clk);
   endtask

   task automatic load_stream(input logic [7:0] csum, input bit gaps);
      start_load();
      for (int i = 1; i <= 12; i++) push(8'(i), gaps);
      push(csum, gaps);
      cfg_valid = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      prog_start = 1'b0;
      prog_abort = 1'b0;
      cfg_data   = 8'h00;
      cfg_valid  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1) Idle after reset; stray valid is ignored.
      cfg_valid = 1'b1;
      cfg_data  = 8'hA5;
      repeat (10) @(negedge clk);
      check("idle_ready", cfg_ready, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_and", and_conf, 64'h0);
      check("idle_or", or_conf, 32'h0);
      check("idle_flags", {programmed, done, error}, 3'b000);
      cfg_valid = 1'b0;

      // 3) Bad checksum.
      load_stream(8'h00, 1'b0);
      check("bad_commit_busy", {busy, cfg_ready}, 2'b10);
      @(negedge clk);
      check("bad_error", error, 1'b1);
      check("bad_flags", {programmed, done, busy}, 3'b000);
      check("bad_and", and_conf, 64'h0);
      check("bad_or", or_conf, 32'h0);
      @(negedge clk);
      check("bad_error_sticky", error, 1'b1);

      // 2) Good load; new start also clears the sticky error.
      start_load();
      check("start_clears_error", error, 1'b0);
      check("start_busy", busy, 1'b1);
      for (int i = 1; i <= 12; i++) push(8'(i), 1'b0);
      push(8'h0C, 1'b0);
      cfg_valid = 1'b0;
      check("good_commit_state", {busy, cfg_ready, done, programmed}, 4'b1000);
      @(negedge clk);
      check("good_done", {done, programmed, busy, error}, 4'b1100);
      check("good_and", and_conf, AndPat);
      check("good_or", or_conf, OrPat);
      check("good_and_lsb", and_conf[7:0], 8'h01);
      check("good_or_lsb", or_conf[7:0], 8'h09);
      @(negedge clk);
      check("done_pulse_once", done, 1'b0);
      check("programmed_holds", programmed, 1'b1);

      // 4) Reprogram with 0xFF, abort on word 5 together with a handshake.
      start_load();
      for (int i = 0; i < 5; i++) push(8'hFF, 1'b0);
      check("reload_keeps_active", and_conf, AndPat);
      check("reload_keeps_prog", programmed, 1'b1);
      cfg_data   = 8'hFF;
      cfg_valid  = 1'b1;
      prog_abort = 1'b1;
      @(negedge clk);
      prog_abort = 1'b0;
      cfg_valid  = 1'b0;
      check("abort_idle", {busy, cfg_ready}, 2'b00);
      check("abort_and", and_conf, AndPat);
      check("abort_or", or_conf, OrPat);
      check("abort_prog", {programmed, done, error}, 3'b100);
      // Abort outside a load is ignored.
      prog_abort = 1'b1;
      @(negedge clk);
      prog_abort = 1'b0;
      check("abort_idle_ignored", programmed, 1'b1);

      // 5) Random valid gaps; start pulsed mid-load must not restart.
      start_load();
      for (int i = 1; i <= 12; i++) begin
         if (i == 6) prog_start = 1'b1;
         push(8'(i), 1'b1);
         prog_start = 1'b0;
      end
      push(8'h0C, 1'b1);
      cfg_valid = 1'b0;
      @(negedge clk);
      check("gaps_done", {done, programmed, error}, 3'b110);
      check("gaps_and", and_conf, AndPat);
      check("gaps_or", or_conf, OrPat);

      // 6) Asynchronous reset in the middle of a load.
      @(negedge clk);
      start_load();
      for (int i = 1; i <= 7; i++) push(8'(i), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_and", and_conf, 64'h0);
      check("rst_async_or", or_conf, 32'h0);
      check("rst_async_flags", {programmed, busy, cfg_ready, done, error}, 5'b0);
      @(negedge clk);
      cfg_valid = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      check("rst_release_idle", {busy, cfg_ready, programmed}, 3'b000);
      start_load();
      check("rst_then_start", {busy, cfg_ready}, 2'b11);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
